// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit and a combinational instruction ROM/RAM.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] Read_address;
  logic [31:0]           instruction_in;

  modport master (output Read_address, input instruction_in);
  modport slave  (input Read_address, output instruction_in);
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: program counter, IF/ID register, stall, redirect with wrong-path squash,
// and a terminal HALT state entered on the halt word or on a bad fetch address.
module instruction_fetch_unit #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [15:0]                 branch_offset,
  input  logic                        jump,
  input  logic [25:0]                 jump_target,
  input  logic                        jr,
  input  logic [31:0]                 jr_address,
  instruction_fetch_unit_if.master    imem,
  output logic [31:0]                 pc,
  output logic [31:0]                 if_instruction,
  output logic [31:0]                 if_pc_plus4,
  output logic                        if_valid,
  output logic                        halted,
  output logic                        fault
);

  typedef enum logic {RUN, HALT} state_t;
  state_t state;

  logic [31:0] pc_plus4;
  logic [31:0] branch_disp;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        bad_pc;

  assign imem.Read_address = pc[ADDR_WIDTH+1:2];
  assign pc_plus4          = pc + 32'd4;
  assign branch_disp       = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign bad_pc            = (pc[1:0] != 2'b00) || (pc[31:ADDR_WIDTH+2] != '0);

  // Redirects belong to the instruction sitting in IF/ID, so a bubble there cannot redirect.
  always_comb begin
    redirect        = if_valid && (jr || jump || branch_taken);
    redirect_target = if_pc_plus4 + branch_disp;
    if (jr)
      redirect_target = jr_address;
    else if (jump)
      redirect_target = {if_pc_plus4[31:28], jump_target, 2'b00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      pc             <= RESET_PC;
      if_instruction <= '0;
      if_pc_plus4    <= '0;
      if_valid       <= 1'b0;
      halted         <= 1'b0;
      fault          <= 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          // A bad pc is caught before its data is ever registered.
          if (bad_pc) begin
            state          <= HALT;
            halted         <= 1'b1;
            fault          <= 1'b1;
            if_valid       <= 1'b0;
            if_instruction <= '0;
          end else if (redirect) begin
            pc             <= redirect_target;
            if_instruction <= '0;
            if_valid       <= 1'b0;
          end else if (imem.instruction_in == HALT_WORD) begin
            state          <= HALT;
            halted         <= 1'b1;
            if_instruction <= HALT_WORD;
            if_pc_plus4    <= pc_plus4;
            if_valid       <= 1'b1;
          end else begin
            pc             <= pc_plus4;
            if_instruction <= imem.instruction_in;
            if_pc_plus4    <= pc_plus4;
            if_valid       <= 1'b1;
          end
        end
        HALT: begin
          if_instruction <= '0;
          if_valid       <= 1'b0;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a small instruction memory model plus
// hand-computed pc / IF/ID expectations per scenario.
module tb_instruction_fetch_unit;

  localparam int ADDR_WIDTH = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_address = '0;
  logic [31:0] pc, if_instruction, if_pc_plus4;
  logic        if_valid, halted, fault;

  logic [31:0] mem [64];
  int vectors = 0;
  int miscompares = 0;

  instruction_fetch_unit_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  assign bus.instruction_in = mem[bus.Read_address];

  instruction_fetch_unit #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_address    (jr_address),
    .imem          (bus.master),
    .pc            (pc),
    .if_instruction(if_instruction),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    vectors++;
    if ({if_valid, halted, fault} !== 3'b000) begin
      miscompares++; $display("[TB] FAIL reset_flags: got %b expected 000", {if_valid, halted, fault});
    end
    vectors++;
    if (if_instruction !== 32'h0 || if_pc_plus4 !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_ifid: got %h/%h expected 0/0", if_instruction, if_pc_plus4);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (bus.Read_address !== 6'd0) begin miscompares++; $display("[TB] FAIL raddr0: got %0d expected 0", bus.Read_address); end
  endtask

  task automatic test_sequential();
    step();
    vectors++;
    if (bus.Read_address !== 6'd1 || if_instruction !== 32'h2008_0001 || if_pc_plus4 !== 32'h4 || if_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL seq1: got ra=%0d ins=%h p4=%h v=%b expected ra=1 ins=20080001 p4=4 v=1",
               bus.Read_address, if_instruction, if_pc_plus4, if_valid);
    end
    step();
    vectors++;
    if (bus.Read_address !== 6'd2 || if_instruction !== 32'h2009_0002 || if_pc_plus4 !== 32'h8 || pc !== 32'h8) begin
      miscompares++;
      $display("[TB] FAIL seq2: got ra=%0d ins=%h p4=%h pc=%h expected ra=2 ins=20090002 p4=8 pc=8",
               bus.Read_address, if_instruction, if_pc_plus4, pc);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_offset = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (pc !== 32'h8 || if_instruction !== 32'h2009_0002 || if_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got pc=%h ins=%h v=%b expected pc=8 ins=20090002 v=1",
                 i, pc, if_instruction, if_valid);
      end
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_offset = '0;
    step();
    vectors++;
    if (pc !== 32'hC || if_instruction !== mem[2] || if_pc_plus4 !== 32'hC) begin
      miscompares++;
      $display("[TB] FAIL stall_resume: got pc=%h ins=%h p4=%h expected pc=c ins=%h p4=c",
               pc, if_instruction, if_pc_plus4, mem[2]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (if_pc_plus4 !== 32'h10 || pc !== 32'h10) begin
      miscompares++; $display("[TB] FAIL br_setup: got p4=%h pc=%h expected 10/10", if_pc_plus4, pc);
    end
    branch_taken = 1'b1;
    branch_offset = 16'hFFFE;
    step();
    branch_taken = 1'b0;
    branch_offset = '0;
    vectors++;
    if (pc !== 32'h8 || if_valid !== 1'b0 || if_instruction !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL br_target: got pc=%h v=%b ins=%h expected pc=8 v=0 ins=0", pc, if_valid, if_instruction);
    end
    step();
    vectors++;
    if (pc !== 32'hC || if_valid !== 1'b1 || if_instruction !== mem[2] || if_pc_plus4 !== 32'hC) begin
      miscompares++;
      $display("[TB] FAIL br_refill: got pc=%h v=%b ins=%h p4=%h expected pc=c v=1 ins=%h p4=c",
               pc, if_valid, if_instruction, if_pc_plus4, mem[2]);
    end
    jump = 1'b1;
    jump_target = 26'h8;
    jr = 1'b1;
    jr_address = 32'h30;
    step();
    jr = 1'b0;
    vectors++;
    if (pc !== 32'h30 || if_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL jr_priority: got pc=%h v=%b expected pc=30 v=0", pc, if_valid);
    end
    // jump still held: the bubble must not redirect
    step();
    vectors++;
    if (pc !== 32'h34 || if_instruction !== mem[12] || if_pc_plus4 !== 32'h34) begin
      miscompares++;
      $display("[TB] FAIL bubble_no_redirect: got pc=%h ins=%h p4=%h expected pc=34 ins=%h p4=34",
               pc, if_instruction, if_pc_plus4, mem[12]);
    end
    jump_target = 26'h4;
    step();
    jump = 1'b0;
    vectors++;
    if (pc !== 32'h10 || if_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL jump_target: got pc=%h v=%b expected pc=10 v=0", pc, if_valid);
    end
  endtask

  task automatic test_halt();
    mem[5] = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    branch_taken = 1'b1;
    branch_offset = 16'h0000;
    step();
    branch_taken = 1'b0;
    vectors++;
    if (pc !== 32'h14 || halted !== 1'b0 || if_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL squashed_halt: got pc=%h h=%b v=%b expected pc=14 h=0 v=0", pc, halted, if_valid);
    end
    step();
    vectors++;
    if (if_instruction !== 32'hFFFF_FFFF || if_valid !== 1'b1 || halted !== 1'b1 || fault !== 1'b0 || pc !== 32'h14) begin
      miscompares++;
      $display("[TB] FAIL halt_enter: got ins=%h v=%b h=%b f=%b pc=%h expected ffffffff 1 1 0 14",
               if_instruction, if_valid, halted, fault, pc);
    end
    jr = 1'b1;
    jr_address = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (pc !== 32'h14 || if_valid !== 1'b0 || if_instruction !== 32'h0 || halted !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL halt_hold%0d: got pc=%h v=%b ins=%h h=%b expected 14 0 0 1",
                 i, pc, if_valid, if_instruction, halted);
      end
    end
    jr = 1'b0;
    mem[5] = 32'h1000_0005;
  endtask

  task automatic test_fault(input logic [31:0] target, input string name);
    do_reset();
    step();
    jr = 1'b1;
    jr_address = target;
    step();
    jr = 1'b0;
    vectors++;
    if (pc !== target || fault !== 1'b0 || if_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_redirect: got pc=%h f=%b v=%b expected pc=%h f=0 v=0", name, pc, fault, if_valid, target);
    end
    step();
    vectors++;
    if (fault !== 1'b1 || halted !== 1'b1 || if_valid !== 1'b0 || pc !== target) begin
      miscompares++;
      $display("[TB] FAIL %s_fault: got f=%b h=%b v=%b pc=%h expected 1 1 0 %h", name, fault, halted, if_valid, pc, target);
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (pc !== 32'h0 || halted !== 1'b0 || fault !== 1'b0 || if_valid !== 1'b0 || if_instruction !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got pc=%h h=%b f=%b v=%b ins=%h expected all zero",
               pc, halted, fault, if_valid, if_instruction);
    end
    #2;
    reset_n = 1'b1;
    step();
    vectors++;
    if (pc !== 32'h4 || if_instruction !== 32'h2008_0001 || if_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart: got pc=%h ins=%h v=%b expected pc=4 ins=20080001 v=1", pc, if_instruction, if_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    $display("[TB] starting instruction_fetch_unit bench");
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_fault(32'h0000_0102, "misaligned");
    test_fault(32'h0000_0100, "out_of_range");
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
